// File: rtl/fir_mac_engine.sv
// fir_mac_engine: multiply-accumulate engine for the FIR datapath.
// Accumulates NUM_TAPS sample x coefficient products per output sample.
// The sum is presented on a valid/ready output register Y. Pairs of the
// next frame keep flowing while Y is held; only the final pair of a frame
// waits for the held result to be taken. 'clear' aborts a partial frame
// without touching a pending result.
module fir_mac_engine #(
    parameter int DATA_W   = 32,
    parameter int COEF_W   = 32,
    parameter int NUM_TAPS = 11,
    parameter int ACC_W    = 68,
    parameter int SIGNED   = 0,
    parameter int IDX_W    = 4
) (
    input  logic              CLK,
    input  logic              Reset,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] X,
    input  logic [COEF_W-1:0] tap,
    output logic [IDX_W-1:0]  tap_idx,
    output logic [ACC_W-1:0]  Y,
    output logic              y_valid,
    input  logic              y_ready,
    output logic              busy
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_TAPS - 1);

    logic [IDX_W-1:0] r_tap_idx;
    logic [ACC_W-1:0] r_acc;
    logic [ACC_W-1:0] r_y;
    logic             r_y_valid;

    logic [ACC_W-1:0] w_x_ext;
    logic [ACC_W-1:0] w_tap_ext;
    logic [ACC_W-1:0] w_prod;
    logic [ACC_W-1:0] w_sum;
    logic             w_last;
    logic             w_in_ready;
    logic             w_fire;

    // Extend both operands to the accumulator width (sign or zero).
    always_comb begin
        w_x_ext   = {ACC_W{1'b0}};
        w_tap_ext = {ACC_W{1'b0}};
        if (SIGNED != 0) begin
            w_x_ext   = {{(ACC_W-DATA_W){X[DATA_W-1]}}, X};
            w_tap_ext = {{(ACC_W-COEF_W){tap[COEF_W-1]}}, tap};
        end else begin
            w_x_ext   = {{(ACC_W-DATA_W){1'b0}}, X};
            w_tap_ext = {{(ACC_W-COEF_W){1'b0}}, tap};
        end
    end

    // Product and running sum, both wrapping modulo 2^ACC_W.
    always_comb begin
        w_prod = w_x_ext * w_tap_ext;
        w_sum  = r_acc + w_prod;
    end

    // Input handshake: only the final pair of a frame waits on a held result;
    // in_valid never feeds in_ready.
    always_comb begin
        w_last     = (r_tap_idx == LAST_IDX);
        w_in_ready = ~Reset & ~clear & ~(r_y_valid & ~y_ready & w_last);
        w_fire     = in_valid & w_in_ready;
    end

    // Tap index: advances on each accepted pair, wraps after the last,
    // and is forced back to zero by a frame abort.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            r_tap_idx <= {IDX_W{1'b0}};
        end else if (clear) begin
            r_tap_idx <= {IDX_W{1'b0}};
        end else if (w_fire) begin
            if (w_last) begin
                r_tap_idx <= {IDX_W{1'b0}};
            end else begin
                r_tap_idx <= r_tap_idx + IDX_W'(1);
            end
        end else begin
            r_tap_idx <= r_tap_idx;
        end
    end

    // Accumulator: the first pair overwrites it so no stale sum survives
    // an aborted frame; later pairs add to it.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            r_acc <= {ACC_W{1'b0}};
        end else if (w_fire) begin
            if (r_tap_idx == {IDX_W{1'b0}}) begin
                r_acc <= w_prod;
            end else begin
                r_acc <= w_sum;
            end
        end else begin
            r_acc <= r_acc;
        end
    end

    // Output register: loads the finished sum on the last accept (even in
    // the same cycle the previous result is taken), otherwise clears the
    // valid flag once downstream consumes it. Y itself holds.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            r_y       <= {ACC_W{1'b0}};
            r_y_valid <= 1'b0;
        end else if (w_fire && w_last) begin
            r_y       <= w_sum;
            r_y_valid <= 1'b1;
        end else if (r_y_valid && y_ready) begin
            r_y       <= r_y;
            r_y_valid <= 1'b0;
        end else begin
            r_y       <= r_y;
            r_y_valid <= r_y_valid;
        end
    end

    // Output mapping; tap_idx, busy, Y and y_valid all come straight from state.
    always_comb begin
        in_ready = w_in_ready;
        tap_idx  = r_tap_idx;
        busy     = (r_tap_idx != {IDX_W{1'b0}});
        Y        = r_y;
        y_valid  = r_y_valid;
    end

endmodule

// File: doc/fir_mac_engine.md
Name: fir_mac_engine

Overview:
Parametrised multiply-accumulate engine for the FIR datapath. It accumulates NUM_TAPS sample×coefficient products per output sample and presents the sum on a valid/ready output. It adds three things to the fixed 11-tap, free-running MAC: input and output handshakes, signed/unsigned mode, and a synchronous frame abort. It sits between the tap/data-RAM sequencer (upstream) and the AXI-Stream output stage (downstream).

Parameters:
DATA_W, 32, sample width (X)
COEF_W, 32, coefficient width (tap)
NUM_TAPS, 11, products per output sample; legal range 2..1024
ACC_W, 68, accumulator/output width; must be ≥ DATA_W+COEF_W
SIGNED, 0, 0 = unsigned operands, 1 = two's-complement operands
IDX_W, 4, tap index width; must be ≥ clog2(NUM_TAPS)

Ports:
CLK  in  1  clock; all logic on rising edge
Reset  in  1  asynchronous, active-high reset
clear  in  1  synchronous abort of the current frame
in_valid  in  1  X/tap pair is valid
in_ready  out  1  engine accepts the pair this cycle
X  in  DATA_W  sample
tap  in  COEF_W  coefficient
tap_idx  out  IDX_W  index of the next pair expected (0..NUM_TAPS-1); upstream uses it for RAM addressing
Y  out  ACC_W  completed sum
y_valid  out  1  Y holds an unconsumed result
y_ready  in  1  downstream takes Y
busy  out  1  frame partially accumulated (tap_idx != 0)

Behaviour:
- Reset (async, asserted): tap_idx=0, acc=0, Y=0, y_valid=0. Outputs are valid during reset: in_ready=0, busy=0. Reset mid-frame discards the partial sum and any pending Y.
- Accept condition: acc_fire = in_valid & in_ready.
- in_ready = ~Reset & ~clear & ~(y_valid & ~y_ready & tap_idx==NUM_TAPS-1).
  - Pairs 0..NUM_TAPS-2 of the next frame are accepted while Y is held.
  - Only the final pair stalls.
- Operand extension: SIGNED=1 sign-extends X and tap to ACC_W; SIGNED=0 zero-extends. The product is taken modulo 2^ACC_W.
- On acc_fire with tap_idx==0: acc <= prod (no stale sum carried over).
- On acc_fire with 0<tap_idx<NUM_TAPS-1: acc <= acc + prod, modulo 2^ACC_W with no saturation. tap_idx increments.
- On acc_fire with tap_idx==NUM_TAPS-1:
  - Y <= acc + prod, y_valid <= 1, tap_idx <= 0.
  - acc value is don't-care afterwards, because the next tap_idx==0 accept overwrites it.
  - Latency: Y/y_valid are visible the cycle after the last accept.
- Output handshake:
  - y_valid & y_ready with no final accept: y_valid <= 0 next cycle, Y unchanged.
  - y_valid & y_ready together with a final accept: Y loads the new sum and y_valid stays 1, giving back-to-back frames with no bubble.
- Y is stable while y_valid=1 and y_ready=0.
- clear=1:
  - tap_idx <= 0; the pair presented that cycle is not accepted (in_ready=0).
  - Y and y_valid are unaffected; clear=1 with y_ready=1 still consumes Y.
- Throughput: one pair per cycle; NUM_TAPS cycles per output at full rate.
- tap_idx and busy are registered-state outputs. in_ready is combinational from state, clear, Reset and y_ready; there is no path from in_valid.

Test Plan:
1. Defaults. Feed X=1..11, tap=2, in_valid=1, y_ready=1 → in_ready held 1; tap_idx 0→10→0; Y=132 with y_valid=1 for exactly one cycle, one cycle after the 11th accept.
2. Backpressure. After test 1's frame, hold y_ready=0 and feed X=1, tap=1 → 10 pairs accepted, in_ready=0 at tap_idx=10, Y stays 132. Raise y_ready → 11th pair accepted that cycle; next cycle Y=11, y_valid=1.
3. Signed. SIGNED=1, X=0xFFFFFFFD (-3), tap=5 ×11 → Y = 2^68-165 (0xFFFFFFFFFFFFFFF5B).
4. Unsigned max. X=tap=0xFFFFFFFF ×11 → Y = 11×(2^32-1)^2 exactly, with no wrap at ACC_W=68.
5. Clear. Pulse clear after 5 accepts, with in_valid=1 in the clear cycle (that pair is not accepted) → tap_idx=0, busy=0. Then 11 pairs of X=1, tap=1 → Y=11 with no contribution from the aborted frame; a pending Y is unaffected by clear.
6. Reset mid-operation. Assert Reset asynchronously after 7 accepts while y_valid=1 → Y=0, y_valid=0, tap_idx=0, in_ready=0 immediately. After release, test 1's stimulus with random in_valid bubbles and random y_ready stalls → Y=132.
